microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer.sv | 156 +++++++++++++++
 tb/tb_microcode_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: a writable control store addressed {op,step} feeds a
// registered control word f. An accepted opcode plays its steps in order
// until the entry's end flag is set or the last step index is reached.
//
// Handshake: an opcode transfers on a rising clk edge where op_valid=1 and
// op_ready=1. op_ready is 1 in IDLE, and in RUN only on the final word of
// the current op when not stalled. When op_ready=0, op is ignored and
// nothing is queued.
module microcode_sequencer #(
  parameter int              OP_W     = 4,
  parameter int              STEP_W   = 2,
  parameter int              CW_W     = 16,
  parameter logic [CW_W-1:0] NOP_WORD = 16'h0709
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  input  logic [OP_W-1:0]          op,
  output logic                     op_ready,
  input  logic                     stall,
  output logic [CW_W-1:0]          f,
  output logic [STEP_W-1:0]        step,
  output logic                     busy,
  output logic                     done,
  input  logic                     wr_en,
  input  logic [OP_W+STEP_W-1:0]   wr_addr,
  input  logic [CW_W:0]            wr_data
);

  localparam int AW    = OP_W + STEP_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CW_W-1:0]     f_q, f_d;
  logic                end_q, end_d;
  logic [CW_W:0]       store_q [DEPTH];
  logic [CW_W:0]       store_d [DEPTH];

  logic                last;
  logic                accept;
  logic                load;
  logic [AW-1:0]       load_addr;
  logic [CW_W:0]       rd_word;
  logic [STEP_W-1:0]   step_inc;

  // Status decode; last is true on the final word of the running op.
  always_comb begin
    busy     = (state_q == RUN);
    last     = end_q | (step_q == {STEP_W{1'b1}});
    done     = busy & last;
    op_ready = busy ? (last & ~stall) : 1'b1;
    accept   = op_valid & op_ready;
    step_inc = step_q + 1'b1;
  end

  // Store write port; reads elsewhere see store_q, so same-edge reads get old data.
  always_comb begin
    store_d = store_q;
    if (wr_en) begin
      store_d[wr_addr] = wr_data;
    end
  end

  // Next-state logic: accept, advance, hold on stall, or return to IDLE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    step_d    = step_q;
    f_d       = f_q;
    end_d     = end_q;
    load      = 1'b0;
    load_addr = {op, {STEP_W{1'b0}}};
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          op_d      = op;
          step_d    = '0;
          load      = 1'b1;
          load_addr = {op, {STEP_W{1'b0}}};
        end
      end
      RUN: begin
        if (!stall) begin
          if (!last) begin
            step_d    = step_inc;
            load      = 1'b1;
            load_addr = {op_q, step_inc};
          end else if (accept) begin
            op_d      = op;
            step_d    = '0;
            load      = 1'b1;
            load_addr = {op, {STEP_W{1'b0}}};
          end else begin
            state_d = IDLE;
            step_d  = '0;
            f_d     = NOP_WORD;
            end_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        f_d     = NOP_WORD;
        end_d   = 1'b0;
      end
    endcase
    rd_word = store_q[load_addr];
    if (load) begin
      f_d   = rd_word[CW_W-1:0];
      end_d = rd_word[CW_W];
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      step_q  <= '0;
      f_q     <= NOP_WORD;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      f_q     <= f_d;
      end_q   <= end_d;
    end
  end

  // Control store; every entry returns to the idle word on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= {1'b0, NOP_WORD};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  assign f    = f_q;
  assign step = step_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: per-cycle vector table plus hand-written
// reset-abort and store-reset sequences.
module tb_microcode_sequencer;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op;
  logic        op_ready;
  logic        stall;
  logic [15:0] f;
  logic [1:0]  step;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [16:0] wr_data;

  int checks;
  int failures;

  microcode_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .op_ready (op_ready),
    .stall    (stall),
    .f        (f),
    .step     (step),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [3:0]  op;
    logic        st;
    logic        we;
    logic [5:0]  wa;
    logic [16:0] wd;
    logic [15:0] ef;
    logic [1:0]  es;
    logic        eb;
    logic        ed;
    logic        er;
  } vec_t;

  localparam int NV = 42;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ov, input logic [3:0] o, input logic st,
                              input logic we, input logic [5:0] wa, input logic [16:0] wd,
                              input logic [15:0] ef, input logic [1:0] es,
                              input logic eb, input logic ed, input logic er);
    vec_t v;
    v.ov = ov; v.op = o; v.st = st; v.we = we; v.wa = wa; v.wd = wd;
    v.ef = ef; v.es = es; v.eb = eb; v.ed = ed; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ef, input logic [1:0] es,
                            input logic eb, input logic ed, input logic er);
    check({tag, ".f"},        32'(f),        32'(ef));
    check({tag, ".step"},     32'(step),     32'(es));
    check({tag, ".busy"},     32'(busy),     32'(eb));
    check({tag, ".done"},     32'(done),     32'(ed));
    check({tag, ".op_ready"}, 32'(op_ready), 32'(er));
  endtask

  initial begin
    int n;
    logic got_done;
    checks   = 0;
    failures = 0;

    // Columns: op_valid op stall wr_en wr_addr wr_data | f step busy done op_ready
    // Default store, op 3 runs all four steps.
    vecs[0]  = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[1]  = mk(1, 3, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 2, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 3, 1, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    // Program op 5 with an early end, then run it.
    vecs[7]  = mk(0, 0, 0, 1, 6'h14, 17'h0_C709,  16'h0709, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 6'h15, 17'h1_1234,  16'h0709, 0, 0, 0, 1);
    vecs[9]  = mk(1, 5, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'hC709, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h1234, 1, 1, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    // Stall op 3 at step 1 for 3 cycles; offered op ignored; store written mid-stall.
    vecs[13] = mk(1, 3, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[14] = mk(1, 5, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 1, 0, 0);
    vecs[15] = mk(1, 5, 1, 0, 6'h00, 17'h0,       16'h0709, 1, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 6'h0E, 17'h0_5555,  16'h0709, 1, 1, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 6'h00, 17'h0,       16'h0709, 1, 1, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 1, 1, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h5555, 2, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 3, 1, 1, 1);
    vecs[21] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    // Stall on the done word: done stays high, op_ready low, offer ignored.
    vecs[22] = mk(1, 5, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'hC709, 0, 1, 0, 0);
    vecs[24] = mk(1, 3, 1, 0, 6'h00, 17'h0,       16'h1234, 1, 1, 1, 0);
    vecs[25] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h1234, 1, 1, 1, 1);
    vecs[26] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    // Back-to-back op 5 then op 3 with no bubble.
    vecs[27] = mk(1, 5, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[28] = mk(1, 3, 0, 0, 6'h00, 17'h0,       16'hC709, 0, 1, 0, 0);
    vecs[29] = mk(1, 3, 0, 0, 6'h00, 17'h0,       16'h1234, 1, 1, 1, 1);
    vecs[30] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 1, 0, 0);
    vecs[31] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 1, 1, 0, 0);
    vecs[32] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h5555, 2, 1, 0, 0);
    vecs[33] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 3, 1, 1, 1);
    vecs[34] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    // Same-edge write of {5,1}: running op sees old word, rerun sees new.
    vecs[35] = mk(1, 5, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[36] = mk(0, 0, 0, 1, 6'h15, 17'h1_ABCD,  16'hC709, 0, 1, 0, 0);
    vecs[37] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h1234, 1, 1, 1, 1);
    vecs[38] = mk(1, 5, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);
    vecs[39] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'hC709, 0, 1, 0, 0);
    vecs[40] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'hABCD, 1, 1, 1, 1);
    vecs[41] = mk(0, 0, 0, 0, 6'h00, 17'h0,       16'h0709, 0, 0, 0, 1);

    // Reset.
    rst = 1'b1; op_valid = 1'b0; op = '0; stall = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 16'h0709, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Table: inputs driven on negedge, outputs checked before the next posedge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      op_valid = vecs[i].ov; op = vecs[i].op; stall = vecs[i].st;
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      #1 check_outs($sformatf("vec%0d", i), vecs[i].ef, vecs[i].es, vecs[i].eb, vecs[i].ed, vecs[i].er);
    end

    // Reset mid-RUN aborts op 3 immediately.
    @(negedge clk);
    op_valid = 1'b1; op = 4'd3; stall = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    #1 check_outs("mid_run", 16'h0709, 2'd1, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_outs("async_rst", 16'h0709, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Store is back to the idle word: op 5 runs four NOP steps.
    @(negedge clk);
    op_valid = 1'b1; op = 4'd5;
    @(negedge clk);
    op_valid = 1'b0;
    #1 check_outs("post_rst_s0", 16'h0709, 2'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    got_done = done;
    while (!got_done && n < 8) begin
      @(negedge clk);
      n++;
      #1 got_done = done;
    end
    check("post_rst_done_seen", 32'(got_done), 32'd1);
    check("post_rst_done_cycles", 32'(n), 32'd3);
    check("post_rst_done_step", 32'(step), 32'd3);
    @(negedge clk);
    #1 check_outs("post_rst_idle", 16'h0709, 2'd0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
